// File: rtl/toe_hdr_tx.sv
// TCP/IPv4 header frame generator: latches connection fields, computes the IPv4
// header checksum over 10 cycles, then streams a 54-byte Ethernet+IPv4+TCP header.
module toe_hdr_tx #(
    parameter logic [7:0]  TTL    = 8'd64,
    parameter logic [15:0] WINDOW = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [47:0] mac_dst,
    input  logic [47:0] mac_src,
    input  logic [31:0] ip_src,
    input  logic [31:0] ip_dst,
    input  logic [15:0] port_src,
    input  logic [15:0] port_dst,
    input  logic [31:0] seq,
    input  logic [31:0] ack,
    input  logic [5:0]  flags,
    output logic        busy,
    output logic        done,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_sop,
    output logic        tx_eop,
    input  logic        tx_ready
);

    typedef enum logic [1:0] {
        IDLE,
        CSUM,
        SEND,
        DONE
    } state_t;

    localparam logic [5:0] LAST_BYTE = 6'd53;
    localparam logic [3:0] LAST_WORD = 4'd9;

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [3:0]  word_q, word_d;
    logic [16:0] acc_q, acc_d;
    logic [15:0] ip_id_q, ip_id_d;

    logic [47:0] mac_dst_q, mac_dst_d;
    logic [47:0] mac_src_q, mac_src_d;
    logic [31:0] ip_src_q, ip_src_d;
    logic [31:0] ip_dst_q, ip_dst_d;
    logic [15:0] port_src_q, port_src_d;
    logic [15:0] port_dst_q, port_dst_d;
    logic [31:0] seq_q, seq_d;
    logic [31:0] ack_q, ack_d;
    logic [5:0]  flags_q, flags_d;

    logic [15:0]  csum_word;
    logic [16:0]  acc_add;
    logic [16:0]  fold1;
    logic [15:0]  sum16;
    logic [15:0]  ip_csum;
    logic [431:0] frame;
    logic [8:0]   byte_msb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            word_q     <= '0;
            acc_q      <= '0;
            ip_id_q    <= '0;
            mac_dst_q  <= '0;
            mac_src_q  <= '0;
            ip_src_q   <= '0;
            ip_dst_q   <= '0;
            port_src_q <= '0;
            port_dst_q <= '0;
            seq_q      <= '0;
            ack_q      <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            acc_q      <= acc_d;
            ip_id_q    <= ip_id_d;
            mac_dst_q  <= mac_dst_d;
            mac_src_q  <= mac_src_d;
            ip_src_q   <= ip_src_d;
            ip_dst_q   <= ip_dst_d;
            port_src_q <= port_src_d;
            port_dst_q <= port_dst_d;
            seq_q      <= seq_d;
            ack_q      <= ack_d;
            flags_q    <= flags_d;
        end
    end

    // IPv4 header words in checksum order; the checksum field itself counts as zero.
    always_comb begin
        csum_word = 16'h0000;
        unique case (word_q)
            4'd0:    csum_word = 16'h4500;
            4'd1:    csum_word = 16'h0028;
            4'd2:    csum_word = ip_id_q;
            4'd3:    csum_word = 16'h4000;
            4'd4:    csum_word = {TTL, 8'h06};
            4'd6:    csum_word = ip_src_q[31:16];
            4'd7:    csum_word = ip_src_q[15:0];
            4'd8:    csum_word = ip_dst_q[31:16];
            4'd9:    csum_word = ip_dst_q[15:0];
            default: csum_word = 16'h0000;
        endcase
    end

    always_comb begin
        acc_add = {1'b0, acc_q[15:0]} + {1'b0, csum_word} + {16'd0, acc_q[16]};
        fold1   = {1'b0, acc_q[15:0]} + {16'd0, acc_q[16]};
        sum16   = fold1[15:0] + {15'd0, fold1[16]};
        ip_csum = ~sum16;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        word_d     = word_q;
        acc_d      = acc_q;
        ip_id_d    = ip_id_q;
        mac_dst_d  = mac_dst_q;
        mac_src_d  = mac_src_q;
        ip_src_d   = ip_src_q;
        ip_dst_d   = ip_dst_q;
        port_src_d = port_src_q;
        port_dst_d = port_dst_q;
        seq_d      = seq_q;
        ack_d      = ack_q;
        flags_d    = flags_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CSUM;
                    idx_d      = '0;
                    word_d     = '0;
                    acc_d      = '0;
                    mac_dst_d  = mac_dst;
                    mac_src_d  = mac_src;
                    ip_src_d   = ip_src;
                    ip_dst_d   = ip_dst;
                    port_src_d = port_src;
                    port_dst_d = port_dst;
                    seq_d      = seq;
                    ack_d      = ack;
                    flags_d    = flags;
                end
            end
            CSUM: begin
                acc_d = acc_add;
                if (word_q == LAST_WORD) begin
                    state_d = SEND;
                    word_d  = '0;
                end else begin
                    word_d = word_q + 4'd1;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx_q == LAST_BYTE) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                ip_id_d = ip_id_q + 16'd1;
            end
        endcase
    end

    // Whole header as one big-endian vector; byte 0 occupies the top 8 bits.
    always_comb begin
        frame = {mac_dst_q, mac_src_q, 16'h0800,
                 32'h4500_0028, ip_id_q, 16'h4000, TTL, 8'h06, ip_csum,
                 ip_src_q, ip_dst_q,
                 port_src_q, port_dst_q, seq_q, ack_q,
                 8'h50, 2'b00, flags_q, WINDOW, 16'h0000, 16'h0000};
        byte_msb = 9'd431 - {idx_q, 3'b000};
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        tx_valid = (state_q == SEND);
        tx_sop   = tx_valid && (idx_q == 6'd0);
        tx_eop   = tx_valid && (idx_q == LAST_BYTE);
        tx_data  = tx_valid ? frame[byte_msb -: 8] : 8'h00;
    end

endmodule

// File: tb/tb_toe_hdr_tx.sv
// Directed bench for toe_hdr_tx: reset, basic frame, back-to-back, backpressure,
// start while busy and ip_id wrap.
module tb_toe_hdr_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [47:0] mac_dst = '0, mac_src = '0;
    logic [31:0] ip_src = '0, ip_dst = '0;
    logic [15:0] port_src = '0, port_dst = '0;
    logic [31:0] seq = '0, ack = '0;
    logic [5:0]  flags = '0;
    logic        tx_ready = 1'b1;
    logic        busy, done, tx_valid, tx_sop, tx_eop;
    logic [7:0]  tx_data;

    toe_hdr_tx #(.TTL(8'd64), .WINDOW(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mac_dst(mac_dst), .mac_src(mac_src),
        .ip_src(ip_src), .ip_dst(ip_dst),
        .port_src(port_src), .port_dst(port_dst),
        .seq(seq), .ack(ack), .flags(flags),
        .busy(busy), .done(done),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [47:0] f_mac_dst, f_mac_src;
    logic [31:0] f_ip_src, f_ip_dst, f_seq, f_ack;
    logic [15:0] f_port_src, f_port_dst;
    logic [5:0]  f_flags;

    logic [7:0] exp_b [54];
    logic [7:0] got_b [54];
    logic       got_sop [54];
    logic       got_eop [54];
    int         n_got, first_cyc, n_stall;
    logic       done_early, done_after, done_gone, busy_after;
    logic [7:0] stall_d [5];
    logic [1:0] stall_se [5];

    task automatic set_basic();
        f_mac_dst  = 48'h4444_4444_4444;
        f_mac_src  = 48'h3333_3333_3333;
        f_ip_src   = 32'h1111_1111;
        f_ip_dst   = 32'h2222_2222;
        f_port_src = 16'h5555;
        f_port_dst = 16'h6666;
        f_seq      = 32'h0;
        f_ack      = 32'h0;
        f_flags    = 6'h02;
    endtask

    function automatic void build_exp(input logic [15:0] id, input logic [15:0] cs);
        logic [431:0] v;
        v = {f_mac_dst, f_mac_src, 16'h0800, 32'h4500_0028, id, 16'h4000, 8'd64, 8'h06, cs,
             f_ip_src, f_ip_dst, f_port_src, f_port_dst, f_seq, f_ack,
             8'h50, 2'b00, f_flags, 16'hFFFF, 32'h0};
        for (int i = 0; i < 54; i++) exp_b[i] = v[431 - 8*i -: 8];
    endfunction

    // Runs one frame from IDLE, recording every transferred byte with its sop/eop.
    task automatic run_frame(input int stall_at, input int stall_len, input bit poke);
        int cyc;
        for (int i = 0; i < 54; i++) begin
            got_b[i] = 8'hxx; got_sop[i] = 1'bx; got_eop[i] = 1'bx;
        end
        n_got = 0; first_cyc = -1; n_stall = 0; done_early = 1'b0;
        @(negedge clk);
        mac_dst = f_mac_dst; mac_src = f_mac_src; ip_src = f_ip_src; ip_dst = f_ip_dst;
        port_src = f_port_src; port_dst = f_port_dst; seq = f_seq; ack = f_ack; flags = f_flags;
        start = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (n_got < 54 && cyc < 300) begin
            tx_ready = 1'b1;
            if (tx_valid && n_got == stall_at && n_stall < stall_len) begin
                tx_ready = 1'b0;
                stall_d[n_stall] = tx_data;
                stall_se[n_stall] = {tx_sop, tx_eop};
                n_stall++;
            end
            if (tx_valid && first_cyc < 0) first_cyc = cyc;
            if (done) done_early = 1'b1;
            if (poke && (cyc == 3 || (tx_valid && n_got == 10))) begin
                start = 1'b1;
                mac_dst = 48'hAAAA_BBBB_CCCC; mac_src = 48'h0102_0304_0506;
                ip_src = 32'hDEAD_BEEF; ip_dst = 32'hC0A8_0001;
                port_src = 16'h1234; port_dst = 16'h4321;
                seq = 32'h8765_4321; ack = 32'h1357_9BDF; flags = 6'h3F;
            end else begin
                start = 1'b0;
            end
            if (tx_valid && tx_ready) begin
                got_b[n_got] = tx_data; got_sop[n_got] = tx_sop; got_eop[n_got] = tx_eop;
                n_got++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; tx_ready = 1'b1;
        done_after = done;
        @(negedge clk);
        done_gone = !done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        int cyc, n;
        logic bad;
        rst = 1'b0; start = 1'b0; tx_ready = 1'b1;
        set_basic();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, tx_valid, tx_sop, tx_eop, tx_data} !== 13'h0) begin
            failures++;
            $display("FAIL reset_idle_outputs got=%b exp=0", {busy, done, tx_valid, tx_sop, tx_eop, tx_data});
        end
        rst = 1'b1;
        @(negedge clk);
        mac_dst = f_mac_dst; mac_src = f_mac_src; ip_src = f_ip_src; ip_dst = f_ip_dst;
        port_src = f_port_src; port_dst = f_port_dst; seq = f_seq; ack = f_ack; flags = f_flags;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; n = 0;
        while (n < 20 && cyc < 200) begin
            if (tx_valid && tx_ready) n++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (n != 20) begin
            failures++;
            $display("FAIL reset_reach_send got=%0d bytes exp=20", n);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, tx_valid, tx_sop, tx_eop, tx_data} !== 13'h0) begin
            failures++;
            $display("FAIL reset_mid_send got=%b exp=0", {busy, done, tx_valid, tx_sop, tx_eop, tx_data});
        end
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || tx_eop || tx_valid) bad = 1'b1;
        end
        rst = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (done || tx_eop || tx_valid || busy) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL reset_abandon got=activity exp=none");
        end
    endtask

    task automatic test_basic();
        set_basic();
        run_frame(-1, 0, 1'b0);
        build_exp(16'h0000, 16'hD46A);
        checks++;
        if (n_got != 54) begin failures++; $display("FAIL basic_count got=%0d exp=54", n_got); end
        checks++;
        if (first_cyc != 11) begin failures++; $display("FAIL basic_latency got=%0d exp=11", first_cyc); end
        checks++;
        if ({got_b[0], got_sop[0]} !== 9'h089) begin failures++; $display("FAIL basic_byte0_sop got=%h/%b exp=44/1", got_b[0], got_sop[0]); end
        checks++;
        if ({got_b[12], got_b[13]} !== 16'h0800) begin failures++; $display("FAIL basic_ethertype got=%h exp=0800", {got_b[12], got_b[13]}); end
        checks++;
        if ({got_b[18], got_b[19]} !== 16'h0000) begin failures++; $display("FAIL basic_ip_id got=%h exp=0000", {got_b[18], got_b[19]}); end
        checks++;
        if ({got_b[24], got_b[25]} !== 16'hD46A) begin failures++; $display("FAIL basic_csum got=%h exp=D46A", {got_b[24], got_b[25]}); end
        checks++;
        if (got_b[47] !== 8'h02) begin failures++; $display("FAIL basic_flags got=%h exp=02", got_b[47]); end
        checks++;
        if ({got_b[53], got_eop[53]} !== 9'h001) begin failures++; $display("FAIL basic_byte53_eop got=%h/%b exp=00/1", got_b[53], got_eop[53]); end
        for (int i = 0; i < 54; i++) begin
            checks++;
            if (got_b[i] !== exp_b[i] || got_sop[i] !== (i == 0) || got_eop[i] !== (i == 53)) begin
                failures++;
                $display("FAIL basic_byte%0d got=%h sop=%b eop=%b exp=%h", i, got_b[i], got_sop[i], got_eop[i], exp_b[i]);
            end
        end
        checks++;
        if ({done_early, done_after, done_gone, busy_after} !== 4'b0110) begin
            failures++;
            $display("FAIL basic_done got=early%b/after%b/gone%b/busy%b exp=0/1/1/0", done_early, done_after, done_gone, busy_after);
        end
    endtask

    task automatic test_back_to_back();
        set_basic();
        run_frame(-1, 0, 1'b0);
        build_exp(16'h0001, 16'hD469);
        checks++;
        if ({got_b[18], got_b[19]} !== 16'h0001) begin failures++; $display("FAIL b2b_ip_id got=%h exp=0001", {got_b[18], got_b[19]}); end
        checks++;
        if ({got_b[24], got_b[25]} !== 16'hD469) begin failures++; $display("FAIL b2b_csum got=%h exp=D469", {got_b[24], got_b[25]}); end
        for (int i = 0; i < 54; i++) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin
                failures++;
                $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_b[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        set_basic();
        run_frame(20, 5, 1'b0);
        build_exp(16'h0000, 16'hD46A);
        checks++;
        if (n_stall != 5) begin failures++; $display("FAIL bp_stall_cycles got=%0d exp=5", n_stall); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (stall_d[i] !== 8'h40 || stall_se[i] !== 2'b00) begin
                failures++;
                $display("FAIL bp_hold%0d got=%h se=%b exp=40 se=00", i, stall_d[i], stall_se[i]);
            end
        end
        checks++;
        if (n_got != 54) begin failures++; $display("FAIL bp_count got=%0d exp=54", n_got); end
        for (int i = 0; i < 54; i++) begin
            checks++;
            if (got_b[i] !== exp_b[i] || got_sop[i] !== (i == 0) || got_eop[i] !== (i == 53)) begin
                failures++;
                $display("FAIL bp_byte%0d got=%h sop=%b eop=%b exp=%h", i, got_b[i], got_sop[i], got_eop[i], exp_b[i]);
            end
        end
        checks++;
        if (done_after !== 1'b1) begin failures++; $display("FAIL bp_done got=%b exp=1", done_after); end
    endtask

    task automatic test_start_while_busy();
        logic extra;
        set_basic();
        run_frame(-1, 0, 1'b1);
        build_exp(16'h0001, 16'hD469);
        for (int i = 0; i < 54; i++) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin
                failures++;
                $display("FAIL busy_byte%0d got=%h exp=%h", i, got_b[i], exp_b[i]);
            end
        end
        extra = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (tx_valid || busy) extra = 1'b1;
        end
        checks++;
        if (extra !== 1'b0) begin failures++; $display("FAIL busy_extra_frame got=1 exp=0"); end
        run_frame(-1, 0, 1'b0);
        checks++;
        if ({got_b[18], got_b[19]} !== 16'h0002) begin failures++; $display("FAIL busy_ip_id_next got=%h exp=0002", {got_b[18], got_b[19]}); end
        checks++;
        if ({got_b[24], got_b[25]} !== 16'hD468) begin failures++; $display("FAIL busy_csum_next got=%h exp=D468", {got_b[24], got_b[25]}); end
    endtask

    task automatic test_ip_id_wrap();
        set_basic();
        // Preload the id counter to its last value rather than streaming 65535 frames.
        @(negedge clk);
        force dut.ip_id_q = 16'hFFFF;
        @(negedge clk);
        release dut.ip_id_q;
        run_frame(-1, 0, 1'b0);
        checks++;
        if ({got_b[18], got_b[19], got_b[24], got_b[25]} !== 32'hFFFF_D46A) begin
            failures++;
            $display("FAIL wrap_ffff got=%h exp=FFFFD46A", {got_b[18], got_b[19], got_b[24], got_b[25]});
        end
        run_frame(-1, 0, 1'b0);
        build_exp(16'h0000, 16'hD46A);
        checks++;
        if ({got_b[18], got_b[19]} !== 16'h0000) begin failures++; $display("FAIL wrap_ip_id got=%h exp=0000", {got_b[18], got_b[19]}); end
        for (int i = 0; i < 54; i++) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin
                failures++;
                $display("FAIL wrap_byte%0d got=%h exp=%h", i, got_b[i], exp_b[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_start_while_busy();
        test_ip_id_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toe_hdr_tx.md
TOE_HDR_TX -- requirements
Module: toe_hdr_tx

Interface
REQ-001 SHALL have parameter TTL, default 8'd64: IPv4 time-to-live byte.
REQ-002 SHALL have parameter WINDOW, default 16'hFFFF: TCP window field.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: request one header frame.
REQ-006 SHALL have ports mac_dst and mac_src, input, 48 each: Ethernet addresses.
REQ-007 SHALL have ports ip_src and ip_dst, input, 32 each: IPv4 addresses.
REQ-008 SHALL have ports port_src and port_dst, input, 16 each: TCP ports.
REQ-009 SHALL have ports seq and ack, input, 32 each: TCP sequence/ack numbers.
REQ-010 SHALL have port flags, input, 6: TCP flags {URG,ACK,PSH,RST,SYN,FIN}.
REQ-011 SHALL have port busy, output, 1: frame in progress.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have ports tx_data (output, 8), tx_valid (output, 1), tx_sop (output, 1), tx_eop (output, 1), tx_ready (input, 1): byte stream to MAC.

Function
REQ-014 SHALL implement states IDLE, CSUM, SEND, DONE; IDLE->CSUM on start, CSUM->SEND after 10 cycles, SEND->DONE on transfer of byte 53, DONE->IDLE after 1 cycle.
REQ-015 SHALL latch all field inputs on the edge that accepts start in IDLE; later input changes do not affect the frame.
REQ-016 SHALL ignore start in any state other than IDLE.
REQ-017 SHALL assert busy from the accept edge until return to IDLE; done high only in DONE.
REQ-018 SHALL in CSUM add one 16-bit IPv4 header word per cycle (10 words, checksum word = 0) with end-around carry into a 17-bit accumulator, checksum = bitwise NOT of final 16-bit sum.
REQ-019 SHALL emit exactly 54 bytes, big-endian per field: mac_dst, mac_src, 08 00; 45 00 00 28, ip_id, 40 00, TTL, 06, checksum, ip_src, ip_dst; port_src, port_dst, seq, ack, 50, {2'b00,flags}, WINDOW, 00 00 (TCP checksum, not computed this revision), 00 00.
REQ-020 SHALL keep a 16-bit ip_id counter, 0 after reset, incremented on each DONE, wrapping FFFF->0000.
REQ-021 SHALL assert tx_valid only in SEND; first byte valid on the 11th cycle after the accept edge.
REQ-022 SHALL advance byte index only when tx_valid && tx_ready; tx_data/tx_sop/tx_eop held stable while tx_valid && !tx_ready.
REQ-023 SHALL assert tx_sop with byte 0 only and tx_eop with byte 53 only.
REQ-024 SHALL keep tx_valid low and stall nothing in CSUM regardless of tx_ready.

Reset
REQ-025 SHALL on rst low, immediately and in any state: state IDLE, busy 0, done 0, tx_valid 0, tx_sop 0, tx_eop 0, tx_data 8'h00, byte index 0, accumulator 0, ip_id 0.
REQ-026 SHALL abandon a frame interrupted by reset with no eop and no done; first start after release begins a fresh frame.

Verification
REQ-027 SHALL cover reset: rst low mid-SEND -> all outputs at REQ-025 values same cycle, no done.
REQ-028 SHALL cover basic frame: tx_ready=1, mac_dst 44444444_4444, mac_src 33333333_3333, ip_src 11111111, ip_dst 22222222, ports 5555/6666, seq=ack=0, flags 02 -> 54 bytes, byte0 44 with sop, bytes12-13 08 00, bytes18-19 00 00, bytes24-25 D4 6A, byte47 02, byte53 00 with eop, done next cycle.
REQ-029 SHALL cover back-to-back: identical second start after done -> bytes18-19 00 01, bytes24-25 D4 69.
REQ-030 SHALL cover backpressure: tx_ready low 5 cycles while byte 20 presented -> tx_data stays 40, 54 transfers total, byte content identical to REQ-028.
REQ-031 SHALL cover start while busy: pulse start during CSUM and SEND with different fields -> frame content unchanged, no extra frame, ip_id advances by 1 only.
REQ-032 SHALL cover ip_id wrap: 65536 frames -> frame 65537 carries ip_id 00 00.
